uart_rx_byte: RTL and testbench

- Serial-line front end for the Pong game controller; sits directly upstream of the game FSM.
- Turns the asynchronous keyboard/terminal line `in` into 8-bit characters (`received_data`) with a one-cycle strobe (`received`).
- The game's edge detector and key decoder ('y', 'w', 's', 'p', 'l') consume these outputs.
- Frame format: 8N1, LSB first, 16x oversampling, mid-bit majority vote.

---
 rtl/uart_rx_byte.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, 16x oversampling with a mid-bit majority vote.
// A 2-flop synchroniser and a previous-line flop give falling-edge start detection.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and adds a PARITY state.
module uart_rx_byte #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in,
    output logic       received,
    output logic [7:0] received_data,
    output logic       frame_error,
    output logic       busy
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_sync1;
    logic            r_rxS;
    logic            r_rxP;
    logic [TW-1:0]   r_tickCnt;
    logic [3:0]      r_sampleCnt;
    logic [2:0]      r_bitCnt;
    logic [7:0]      r_shift;
    logic            r_vote7;
    logic            r_vote8;
    logic            r_received;
    logic            r_frameError;
    logic [7:0]      r_data;
    logic            w_tick;
    logic            w_sample9;
    logic            w_wrap;
    logic            w_vote;
    logic            w_busy;
    logic            w_frameOk;
    logic            w_frameBad;
`ifdef UART_RX_PARITY_EN
    logic            r_parityBit;
    logic            w_parityOk;
`endif

    assign w_tick    = (r_state != S_IDLE) && (r_tickCnt == TICK_LAST);
    assign w_sample9 = w_tick && (r_sampleCnt == 4'd9);
    assign w_wrap    = w_tick && (r_sampleCnt == 4'd15);
    assign w_vote    = (r_vote7 & r_vote8) | (r_vote7 & r_rxS) | (r_vote8 & r_rxS);
`ifdef UART_RX_PARITY_EN
    assign w_parityOk = ~(^{r_shift, r_parityBit});
`endif

    // Bring the asynchronous line into the clock domain and keep a delayed copy for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_rxS   <= 1'b1;
            r_rxP   <= 1'b1;
        end else begin
            r_sync1 <= in;
            r_rxS   <= r_sync1;
            r_rxP   <= r_rxS;
        end
    end

    // Sample-tick divider and sample counter, both parked at zero in IDLE so their phase follows the start edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tickCnt   <= '0;
            r_sampleCnt <= 4'd0;
        end else if (r_state == S_IDLE) begin
            r_tickCnt   <= '0;
            r_sampleCnt <= 4'd0;
        end else if (w_tick) begin
            r_tickCnt   <= '0;
            r_sampleCnt <= r_sampleCnt + 4'd1;
        end else begin
            r_tickCnt   <= r_tickCnt + TW'(1);
        end
    end

    // Vote capture, bit counter and shift register for the data bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vote7  <= 1'b1;
            r_vote8  <= 1'b1;
            r_bitCnt <= 3'd0;
            r_shift  <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_parityBit <= 1'b0;
`endif
        end else begin
            if (w_tick && r_sampleCnt == 4'd7) r_vote7 <= r_rxS;
            if (w_tick && r_sampleCnt == 4'd8) r_vote8 <= r_rxS;
            if (r_state == S_IDLE || (r_state == S_START && w_wrap)) begin
                r_bitCnt <= 3'd0;
            end else if (r_state == S_DATA && w_wrap) begin
                r_bitCnt <= r_bitCnt + 3'd1;
            end
            if (r_state == S_DATA && w_sample9) r_shift[r_bitCnt] <= w_vote;
`ifdef UART_RX_PARITY_EN
            if (r_state == S_PARITY && w_sample9) r_parityBit <= w_vote;
`endif
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_nextState;
    end

    // Next-state logic; STOP returns to IDLE at mid-bit so a zero-gap next start edge is not missed
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (r_rxP && !r_rxS) w_nextState = S_START;
            S_START: begin
                if (w_sample9 && w_vote) w_nextState = S_IDLE;
                else if (w_wrap)         w_nextState = S_DATA;
            end
            S_DATA: begin
                if (w_wrap && r_bitCnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_nextState = S_PARITY;
`else
                    w_nextState = S_STOP;
`endif
                end
            end
            S_PARITY: if (w_wrap) w_nextState = S_STOP;
            S_STOP:   if (w_sample9) w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // Output decode: busy outside IDLE, and the good/bad frame verdict at the stop-bit vote
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_frameOk  = 1'b0;
        w_frameBad = 1'b0;
        if (r_state == S_STOP && w_sample9) begin
`ifdef UART_RX_PARITY_EN
            w_frameOk  = w_vote && w_parityOk;
`else
            w_frameOk  = w_vote;
`endif
            w_frameBad = !w_frameOk;
        end
    end

    // Registered one-cycle strobes and the held output byte
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_received   <= 1'b0;
            r_frameError <= 1'b0;
            r_data       <= 8'h00;
        end else begin
            r_received   <= w_frameOk;
            r_frameError <= w_frameBad;
            if (w_frameOk) r_data <= r_shift;
        end
    end

    assign received      = r_received;
    assign frame_error   = r_frameError;
    assign received_data = r_data;
    assign busy          = w_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed self-checking bench for uart_rx_byte at 160 clocks per bit.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant as well.
module tb_uart_rx_byte;

    localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
    localparam int EXTRA_BITS = 1;
`else
    localparam int EXTRA_BITS = 0;
`endif
    localparam int LAT_MIN = 1520 + EXTRA_BITS * BIT_CLKS;
    localparam int LAT_MAX = 1560 + EXTRA_BITS * BIT_CLKS;

    logic       clock;
    logic       reset_n;
    logic       in;
    logic       received;
    logic [7:0] received_data;
    logic       frame_error;
    logic       busy;

    int checks;
    int errors;
    int cycle;
    int recvCount;
    int errCount;
    int bothHigh;
    int longRecv;
    int longErr;
    int lastRecvCycle;
    logic [7:0] lastRecvData;
    logic prevRecv;
    logic prevErr;
    logic sawBusy;
`ifdef UART_RX_PARITY_EN
    logic flipParity;
`endif

    uart_rx_byte #(
        .CLOCK_FREQ(1600000),
        .BAUD_RATE (10000),
        .OVERSAMPLE(16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in           (in),
        .received     (received),
        .received_data(received_data),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    // 100 MHz nominal clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running cycle counter for latency measurement
    always @(posedge clock) cycle <= cycle + 1;

    // Observe strobes away from the active edge and tally them
    always @(negedge clock) begin
        if (received) begin
            recvCount = recvCount + 1;
            lastRecvData = received_data;
            lastRecvCycle = cycle;
        end
        if (frame_error) errCount = errCount + 1;
        if (received && frame_error) bothHigh = bothHigh + 1;
        if (received && prevRecv) longRecv = longRecv + 1;
        if (frame_error && prevErr) longErr = longErr + 1;
        if (busy) sawBusy = 1'b1;
        prevRecv = received;
        prevErr = frame_error;
    end

    task automatic driveBit(input logic b);
        in = b;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(d[i]);
`ifdef UART_RX_PARITY_EN
        driveBit((^d) ^ flipParity);
`endif
        driveBit(stopBit);
        in = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (received !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got rcv=%b ferr=%b busy=%b want 0 0 0", received, frame_error, busy);
        end
        checks++;
        if (received_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data got %h want 00", received_data);
        end
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_single_byte();
        int r0, e0, startCycle, lat;
        r0 = recvCount;
        e0 = errCount;
        sawBusy = 1'b0;
        startCycle = cycle;
        sendFrame(8'h79, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_busy_end got %b want 0", busy);
        end
        repeat (40) @(negedge clock);
        checks++;
        if (recvCount - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL single_rcv_count got %0d want 1", recvCount - r0);
        end
        checks++;
        if (lastRecvData !== 8'h79 || received_data !== 8'h79) begin
            errors++;
            $display("[TB] FAIL single_data got %h/%h want 79", lastRecvData, received_data);
        end
        checks++;
        if (errCount - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL single_ferr got %0d want 0", errCount - e0);
        end
        checks++;
        if (sawBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_busy_seen got %b want 1", sawBusy);
        end
        lat = lastRecvCycle - startCycle;
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            errors++;
            $display("[TB] FAIL single_latency got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
    endtask

    task automatic test_back_to_back();
        int r0, firstCycle, gap;
        logic [7:0] firstData;
        r0 = recvCount;
        sendFrame(8'h77, 1'b1);
        firstCycle = lastRecvCycle;
        firstData = lastRecvData;
        sendFrame(8'h73, 1'b1);
        repeat (40) @(negedge clock);
        checks++;
        if (recvCount - r0 !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d want 2", recvCount - r0);
        end
        checks++;
        if (firstData !== 8'h77) begin
            errors++;
            $display("[TB] FAIL b2b_first got %h want 77", firstData);
        end
        checks++;
        if (lastRecvData !== 8'h73) begin
            errors++;
            $display("[TB] FAIL b2b_second got %h want 73", lastRecvData);
        end
        gap = lastRecvCycle - firstCycle;
        checks++;
        if (gap < 1590 + EXTRA_BITS * BIT_CLKS || gap > 1610 + EXTRA_BITS * BIT_CLKS) begin
            errors++;
            $display("[TB] FAIL b2b_spacing got %0d want about %0d", gap, 1600 + EXTRA_BITS * BIT_CLKS);
        end
    endtask

    task automatic test_glitch();
        int r0, e0;
        r0 = recvCount;
        e0 = errCount;
        sawBusy = 1'b0;
        in = 1'b0;
        repeat (40) @(negedge clock);
        in = 1'b1;
        repeat (200) @(negedge clock);
        checks++;
        if (sawBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_busy_seen got %b want 1", sawBusy);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_busy_end got %b want 0", busy);
        end
        checks++;
        if (recvCount - r0 !== 0 || errCount - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_strobes got rcv=%0d ferr=%0d want 0 0", recvCount - r0, errCount - e0);
        end
    endtask

    task automatic test_frame_error();
        int r0, e0;
        r0 = recvCount;
        e0 = errCount;
        sendFrame(8'h70, 1'b0);
        repeat (200) @(negedge clock);
        checks++;
        if (errCount - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL ferr_count got %0d want 1", errCount - e0);
        end
        checks++;
        if (recvCount - r0 !== 0) begin
            errors++;
            $display("[TB] FAIL ferr_no_rcv got %0d want 0", recvCount - r0);
        end
        checks++;
        if (received_data !== 8'h73) begin
            errors++;
            $display("[TB] FAIL ferr_data_hold got %h want 73", received_data);
        end
    endtask

    task automatic test_reset_abort();
        int r0, e0;
        logic [7:0] d;
        d = 8'h6C;
        r0 = recvCount;
        e0 = errCount;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(d[i]);
        in = d[4];
        repeat (BIT_CLKS / 2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || received_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL abort_async got busy=%b data=%h want 0 00", busy, received_data);
        end
        in = 1'b1;
        repeat (20) @(negedge clock);
        reset_n = 1'b1;
        repeat (BIT_CLKS * 12) @(negedge clock);
        checks++;
        if (recvCount - r0 !== 0 || errCount - e0 !== 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_silent got rcv=%0d ferr=%0d busy=%b want 0 0 0", recvCount - r0, errCount - e0, busy);
        end
        sendFrame(8'h6C, 1'b1);
        repeat (40) @(negedge clock);
        checks++;
        if (recvCount - r0 !== 1 || received_data !== 8'h6C) begin
            errors++;
            $display("[TB] FAIL abort_recover got rcv=%0d data=%h want 1 6c", recvCount - r0, received_data);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int r0, e0;
        r0 = recvCount;
        e0 = errCount;
        flipParity = 1'b0;
        sendFrame(8'h79, 1'b1);
        repeat (40) @(negedge clock);
        checks++;
        if (recvCount - r0 !== 1 || received_data !== 8'h79) begin
            errors++;
            $display("[TB] FAIL parity_good got rcv=%0d data=%h want 1 79", recvCount - r0, received_data);
        end
        flipParity = 1'b1;
        sendFrame(8'h6C, 1'b1);
        flipParity = 1'b0;
        repeat (40) @(negedge clock);
        checks++;
        if (errCount - e0 !== 1 || recvCount - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL parity_bad got ferr=%0d rcv=%0d want 1 1", errCount - e0, recvCount - r0);
        end
        checks++;
        if (received_data !== 8'h79) begin
            errors++;
            $display("[TB] FAIL parity_hold got %h want 79", received_data);
        end
    endtask
`endif

    task automatic test_pulse_integrity();
        checks++;
        if (bothHigh !== 0) begin
            errors++;
            $display("[TB] FAIL strobe_exclusive got %0d overlaps want 0", bothHigh);
        end
        checks++;
        if (longRecv !== 0 || longErr !== 0) begin
            errors++;
            $display("[TB] FAIL strobe_width got rcv=%0d ferr=%0d long pulses want 0 0", longRecv, longErr);
        end
    endtask

    // Run the directed scenarios in order, then report
    initial begin
        checks = 0;
        errors = 0;
        cycle = 0;
        recvCount = 0;
        errCount = 0;
        bothHigh = 0;
        longRecv = 0;
        longErr = 0;
        lastRecvCycle = 0;
        lastRecvData = 8'h00;
        prevRecv = 1'b0;
        prevErr = 1'b0;
        sawBusy = 1'b0;
`ifdef UART_RX_PARITY_EN
        flipParity = 1'b0;
`endif
        reset_n = 1'b0;
        in = 1'b1;
        @(negedge clock);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_pulse_integrity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
